mul_pipe: RTL and testbench

MUL_PIPE -- requirements
Module: mul_pipe

---
 rtl/mul_pipe_if.sv | 33 +++
 rtl/mul_pipe.sv | 72 +++++++
 tb/tb_mul_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipe_if.sv
// Operand/result bundle for mul_pipe.
// The master drives operations and hazard queries; the slave returns results and status.
interface mul_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             stall_i;
  logic             flush_i;
  logic             in_valid_i;
  logic [1:0]       op_i;
  logic [XLEN-1:0]  opa_i;
  logic [XLEN-1:0]  opb_i;
  logic [TAG_W-1:0] rd_i;
  logic [TAG_W-1:0] query_rs1_i;
  logic [TAG_W-1:0] query_rs2_i;
  logic             out_valid_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] rd_o;
  logic             busy_o;
  logic             hazard_o;

  modport master (
    output stall_i, flush_i, in_valid_i, op_i, opa_i, opb_i, rd_i,
           query_rs1_i, query_rs2_i,
    input  out_valid_o, result_o, rd_o, busy_o, hazard_o
  );

  modport slave (
    input  stall_i, flush_i, in_valid_i, op_i, opa_i, opb_i, rd_i,
           query_rs1_i, query_rs2_i,
    output out_valid_o, result_o, rd_o, busy_o, hazard_o
  );
endinterface

// File: rtl/mul_pipe.sv
// RV32M-style multiplier: STAGES register stages, result valid STAGES edges after capture.
// stall_i freezes every stage (no internal backpressure); flush_i only kills the incoming op.
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_pipe_if.slave bus
);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic                  w_a_sx;
  logic                  w_b_sx;
  logic [2*XLEN-1:0]     w_a_ext;
  logic [2*XLEN-1:0]     w_b_ext;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_res;
  logic                  w_hazard;

  logic [STAGES-1:0]     r_vld;
  logic [TAG_W-1:0]      r_rd  [STAGES];
  logic [XLEN-1:0]       r_res [STAGES];

  // Extending the XLEN+1-bit signed operands to 2*XLEN keeps the low 2*XLEN
  // product bits exact while the multiply itself stays unsigned.
  assign w_a_sx  = ((bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU)) & bus.opa_i[XLEN-1];
  assign w_b_sx  = (bus.op_i == OP_MULH) & bus.opb_i[XLEN-1];
  assign w_a_ext = {{XLEN{w_a_sx}}, bus.opa_i};
  assign w_b_ext = {{XLEN{w_b_sx}}, bus.opb_i};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_res   = (bus.op_i == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_rd[k]  <= '0;
        r_res[k] <= '0;
      end
    end else if (!bus.stall_i) begin
      r_vld[0] <= bus.in_valid_i & ~bus.flush_i;
      r_rd[0]  <= bus.rd_i;
      r_res[0] <= w_res;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_res[k] <= r_res[k-1];
      end
    end
  end

  // A zero tag never matches, so a zero query cannot raise a hazard either.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (r_vld[k] && (r_rd[k] != '0) &&
          ((r_rd[k] == bus.query_rs1_i) || (r_rd[k] == bus.query_rs2_i))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign bus.out_valid_o = r_vld[STAGES-1];
  assign bus.result_o    = r_res[STAGES-1];
  assign bus.rd_o        = r_rd[STAGES-1];
  assign bus.busy_o      = |r_vld;
  assign bus.hazard_o    = w_hazard;
endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe (XLEN=32, STAGES=2): inputs change on the falling edge, outputs checked there.
module tb_mul_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_pipe_if #(.XLEN(32), .TAG_W(5)) bus ();

  mul_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.in_valid_i = v;
    bus.op_i       = op;
    bus.opa_i      = a;
    bus.opb_i      = b;
    bus.rd_i       = rd;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.stall_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.query_rs1_i = '0;
    bus.query_rs2_i = '0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    step();
    step();
    chk("rst_out_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("rst_result",    bus.result_o,             32'd0);
    chk("rst_rd",        {27'b0, bus.rd_o},        32'd0);
    chk("rst_busy",      {31'b0, bus.busy_o},      32'd0);
    chk("rst_hazard",    {31'b0, bus.hazard_o},    32'd0);
    rst_n = 1'b1;

    // MUL 7 x -3, two-edge latency, one-cycle valid pulse
    drive(1'b1, 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd4);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("mul_e1_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("mul_e1_busy",  {31'b0, bus.busy_o},      32'd1);
    step();
    chk("mul_e2_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("mul_e2_result", bus.result_o,            32'hFFFF_FFEB);
    chk("mul_e2_rd",    {27'b0, bus.rd_o},        32'd4);
    step();
    chk("mul_e3_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("mul_e3_busy",  {31'b0, bus.busy_o},      32'd0);

    // Back-to-back MULH, MULHU, MULHSU with rd 1,2,3
    drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1);
    step();
    drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    step();
    chk("b2b_1_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("b2b_1_rd",    {27'b0, bus.rd_o},        32'd1);
    chk("mulh_result", bus.result_o,             32'h4000_0000);
    drive(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("b2b_2_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("b2b_2_rd",    {27'b0, bus.rd_o},        32'd2);
    chk("mulhu_result", bus.result_o,            32'hFFFF_FFFE);
    step();
    chk("b2b_3_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("b2b_3_rd",    {27'b0, bus.rd_o},        32'd3);
    chk("mulhsu_result", bus.result_o,           32'hFFFF_FFFF);
    step();
    chk("b2b_end_valid", {31'b0, bus.out_valid_o}, 32'd0);

    // Stall for three edges right after issue: result 5 edges after issue
    drive(1'b1, 2'b00, 32'd3, 32'd5, 5'd6);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    bus.stall_i = 1'b1;
    step();
    chk("stall_e2_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("stall_e2_busy",  {31'b0, bus.busy_o},      32'd1);
    // flush and a new op during stall must not disturb anything
    drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd9);
    bus.flush_i = 1'b1;
    step();
    chk("stall_e3_valid", {31'b0, bus.out_valid_o}, 32'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    bus.flush_i = 1'b0;
    step();
    chk("stall_e4_valid", {31'b0, bus.out_valid_o}, 32'd0);
    bus.stall_i = 1'b0;
    step();
    chk("stall_e5_valid", {31'b0, bus.out_valid_o}, 32'd1);
    chk("stall_e5_result", bus.result_o,            32'd15);
    chk("stall_e5_rd",    {27'b0, bus.rd_o},        32'd6);
    bus.stall_i = 1'b1;
    step();
    chk("hold_valid",  {31'b0, bus.out_valid_o}, 32'd1);
    chk("hold_result", bus.result_o,             32'd15);
    bus.stall_i = 1'b0;
    step();
    chk("hold_release_valid", {31'b0, bus.out_valid_o}, 32'd0);

    // Hazard against an in-flight rd=5
    bus.query_rs1_i = 5'd5;
    drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd5);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("haz_rd5_s1", {31'b0, bus.hazard_o}, 32'd1);
    bus.query_rs1_i = 5'd0;
    bus.query_rs2_i = 5'd5;
    step();
    chk("haz_rd5_s2_rs2", {31'b0, bus.hazard_o}, 32'd1);
    chk("haz_rd5_result", bus.result_o,          32'd4);
    bus.query_rs2_i = 5'd0;
    step();
    chk("haz_rd5_gone", {31'b0, bus.hazard_o}, 32'd0);

    // rd=0 is carried but never flags a hazard
    drive(1'b1, 2'b00, 32'd6, 32'd7, 5'd0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("haz_rd0",      {31'b0, bus.hazard_o}, 32'd0);
    chk("haz_rd0_busy", {31'b0, bus.busy_o},   32'd1);
    step();
    chk("rd0_valid",  {31'b0, bus.out_valid_o}, 32'd1);
    chk("rd0_rd",     {27'b0, bus.rd_o},        32'd0);
    chk("rd0_result", bus.result_o,             32'd42);
    step();

    // Flushed issue never becomes valid
    drive(1'b1, 2'b00, 32'd1, 32'd1, 5'd7);
    bus.flush_i = 1'b1;
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    bus.flush_i = 1'b0;
    chk("flush_busy_e1", {31'b0, bus.busy_o}, 32'd0);
    step();
    chk("flush_valid_e2", {31'b0, bus.out_valid_o}, 32'd0);
    chk("flush_busy_e2",  {31'b0, bus.busy_o},      32'd0);

    // Asynchronous reset with two ops in flight
    drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd7);
    step();
    drive(1'b1, 2'b00, 32'd4, 32'd4, 5'd8);
    bus.query_rs1_i = 5'd8;
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("pre_rst_hazard", {31'b0, bus.hazard_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'b0, bus.busy_o},      32'd0);
    chk("arst_valid",  {31'b0, bus.out_valid_o}, 32'd0);
    chk("arst_result", bus.result_o,             32'd0);
    chk("arst_rd",     {27'b0, bus.rd_o},        32'd0);
    chk("arst_hazard", {31'b0, bus.hazard_o},    32'd0);
    #1 rst_n = 1'b1;
    bus.query_rs1_i = 5'd0;
    step();
    chk("post_rst_valid_e1", {31'b0, bus.out_valid_o}, 32'd0);
    step();
    chk("post_rst_valid_e2", {31'b0, bus.out_valid_o}, 32'd0);
    chk("post_rst_busy",     {31'b0, bus.busy_o},      32'd0);

    // Extra directed products
    drive(1'b1, 2'b00, 32'h0000_FFFF, 32'h0001_0001, 5'd10);
    step();
    drive(1'b1, 2'b11, 32'h0000_FFFF, 32'h0001_0001, 5'd11);
    step();
    chk("mul_ffff", bus.result_o, 32'hFFFF_FFFF);
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'd2, 5'd12);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("mulhu_small", bus.result_o, 32'h0000_0000);
    step();
    chk("mulh_neg",    bus.result_o,             32'hFFFF_FFFF);
    chk("mulh_neg_rd", {27'b0, bus.rd_o},        32'd12);
    step();
    chk("final_idle",  {31'b0, bus.busy_o},      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
